// File: rtl/sub8s_recover_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : sub8s_recover_serial_if
//  Description : Request/response bundle for sub8s_recover_serial. The
//                requester drives a known addend A and the adder's 9-bit sum.
//                The responder returns the recovered operand B. The err
//                signal exists only when SUB8S_RANGE_CHECK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sub8s_recover_serial_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [8:0] s;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] b;
`ifdef SUB8S_RANGE_CHECK_EN
  logic       err;
`endif

  // Requester / consumer side
  modport master (
    output in_valid,
    output a,
    output s,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  b
`ifdef SUB8S_RANGE_CHECK_EN
    ,
    input  err
`endif
  );

  // Operand-recovery block side
  modport slave (
    input  in_valid,
    input  a,
    input  s,
    input  out_ready,
    output in_ready,
    output out_valid,
    output b
`ifdef SUB8S_RANGE_CHECK_EN
    ,
    output err
`endif
  );

endinterface : sub8s_recover_serial_if
`default_nettype wire

// File: rtl/sub8s_recover_serial.sv
`default_nettype none
// ============================================================================
//  Module      : sub8s_recover_serial
//  Description : Recovers the signed 8-bit operand B from a known signed
//                addend A and the 9-bit signed sum S = A + B, by computing
//                (S - sext(A)) mod 2^9 one bit per cycle, LSB first. A single
//                full-subtractor cell and one borrow flop do all the work.
//                Each request takes 9 SHIFT cycles; the result is held in DONE
//                until the consumer accepts it.
//  Options     : SUB8S_RANGE_CHECK_EN - adds the err output, flagging a sum
//                whose true difference falls outside -128..127.
//  Revision    : 1.0 - initial release
// ============================================================================
module sub8s_recover_serial (
  input  wire logic                   clk,
  input  wire logic                   rst,
  sub8s_recover_serial_if.slave       io
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Index of the last (sign) bit processed in SHIFT
  localparam logic [3:0] C_LAST_BIT = 4'd8;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0] r_state;
  logic [8:0] r_s_sh;      // sum operand, consumed from bit 0
  logic [8:0] r_a_sh;      // sign-extended addend, consumed from bit 0
  logic [8:0] r_diff_sh;   // difference bits enter at the top
  logic       r_borrow;
  logic [3:0] r_cnt;       // index of the bit processed this cycle
  logic [7:0] r_b;
  logic       r_out_valid;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic       w_accept;
  logic       w_release;
  logic       w_last_bit;
  logic       w_x;
  logic       w_y;
  logic       w_d;
  logic       w_bout;
  logic [8:0] w_diff_next;
  logic       w_unused_diff_lsb;

  assign w_accept   = (r_state == ST_IDLE) && io.in_valid;
  assign w_release  = (r_state == ST_DONE) && io.out_ready;
  assign w_last_bit = (r_state == ST_SHIFT) && (r_cnt == C_LAST_BIT);

  // Full-subtractor cell: x - y - borrow_in
  assign w_x    = r_s_sh[0];
  assign w_y    = r_a_sh[0];
  assign w_d    = w_x ^ w_y ^ r_borrow;
  assign w_bout = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);

  // Difference register after this cycle's bit is shifted in. On the last
  // bit this is the complete 9-bit difference, so results are taken from it
  // directly and land in the same edge that enters DONE.
  assign w_diff_next = {w_d, r_diff_sh[8:1]};

  // The bit falling out of the bottom of the difference register is a
  // leftover from before the current operation and carries no information.
  assign w_unused_diff_lsb = r_diff_sh[0];

  // --------------------------------------------------------------------------
  // Control FSM: IDLE -> SHIFT (9 cycles) -> DONE -> IDLE
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_accept)   r_state <= ST_SHIFT;
        ST_SHIFT: if (w_last_bit) r_state <= ST_DONE;
        ST_DONE:  if (w_release)  r_state <= ST_IDLE;
        default:                  r_state <= ST_IDLE;
      endcase
    end
  end

  // Serial datapath: capture operands on accept, then one bit per SHIFT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_sh    <= 9'd0;
      r_a_sh    <= 9'd0;
      r_diff_sh <= 9'd0;
      r_borrow  <= 1'b0;
      r_cnt     <= 4'd0;
    end else if (w_accept) begin
      r_s_sh    <= io.s;
      r_a_sh    <= {io.a[7], io.a};
      r_borrow  <= 1'b0;
      r_cnt     <= 4'd0;
    end else if (r_state == ST_SHIFT) begin
      r_s_sh    <= {1'b0, r_s_sh[8:1]};
      r_a_sh    <= {1'b0, r_a_sh[8:1]};
      r_diff_sh <= w_diff_next;
      // Borrow out of bit 8 is dropped: the result wraps modulo 2^9
      r_borrow  <= w_last_bit ? 1'b0 : w_bout;
      r_cnt     <= w_last_bit ? 4'd0 : (r_cnt + 4'd1);
    end
  end

  // Result register and valid flag: b is updated only on DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_b         <= 8'h00;
    end else if (w_last_bit) begin
      r_out_valid <= 1'b1;
      r_b         <= w_diff_next[7:0];
    end else if (w_release) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef SUB8S_RANGE_CHECK_EN
  logic r_err;

  // Range flag: bits 8 and 7 disagree when the true difference needs 9 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_last_bit) begin
      r_err <= w_diff_next[8] ^ w_diff_next[7];
    end
  end

  assign io.err = r_err;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign io.in_ready  = (r_state == ST_IDLE);
  assign io.out_valid = r_out_valid;
  assign io.b         = r_b;

endmodule : sub8s_recover_serial
`default_nettype wire

// File: doc/sub8s_recover_serial.md
SUB8S_RECOVER_SERIAL -- requirements
Module: sub8s_recover_serial

Interface
REQ-001 SHALL have no parameters; the operand width is fixed at 8 bits (signed, two's complement) and the sum width at 9 bits.
REQ-002 SHALL provide port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port: in_valid  input  1  request valid.
REQ-005 SHALL provide port: in_ready  output  1  block can accept a request.
REQ-006 SHALL provide port: a  input  8  known signed addend A[7:0].
REQ-007 SHALL provide port: s  input  9  signed 9-bit sum O[8:0] produced by the 8-bit signed adder.
REQ-008 SHALL provide port: out_valid  output  1  result valid.
REQ-009 SHALL provide port: out_ready  input  1  consumer accepts the result.
REQ-010 SHALL provide port: b  output  8  recovered signed operand B[7:0].
REQ-011 SHALL provide port: err  output  1  sum inconsistent with any 8-bit B (present only with RANGE_CHECK_EN).

Function
REQ-012 SHALL compute diff[8:0] = s - sign_extend(a) modulo 2^9, then b = diff[7:0] (the inverse of the adder).
REQ-013 SHALL implement the subtraction bit-serially: one full-subtractor cell, one borrow flop, and 9-bit shift registers for s, a, diff, LSB first.
REQ-014 SHALL use the FSM IDLE -> SHIFT -> DONE -> IDLE.
REQ-015 SHALL drive in_ready = 1 only in IDLE; accept a request when in_valid && in_ready; capture a and s, clear borrow, set the bit counter to 0, and enter SHIFT.
REQ-016 SHALL process exactly one bit per cycle in SHIFT; SHIFT lasts 9 cycles, bit indices 0..8.
REQ-017 SHALL, on the edge that processes bit 8, enter DONE and register out_valid = 1; for an accept at edge k, out_valid is first high after edge k+9.
REQ-018 SHALL hold b, err and out_valid stable in DONE while out_ready = 0 (backpressure of unbounded length).
REQ-019 SHALL, on out_valid && out_ready, go to IDLE and clear out_valid; in_ready is high in the following cycle; there is no overlap between successive requests.
REQ-020 SHALL ignore a, s and in_valid outside of IDLE; input changes during SHIFT do not affect the result.
REQ-021 SHALL keep b holding the last result until the next DONE; b is defined only while out_valid = 1.
REQ-022 SHALL discard the final borrow out of bit 8; wrap-around is modulo 2^9.

Reset
REQ-023 SHALL, while rst = 1 at a clock edge: state = IDLE, out_valid = 0, b = 0x00, err = 0, borrow = 0, counter = 0; in_ready = 1 in the cycle after reset is released.
REQ-024 SHALL, when rst is asserted during SHIFT or DONE, abandon the operation with no out_valid pulse; rst overrides a simultaneous handshake.

Configuration
REQ-025 SHALL, when macro SUB8S_RANGE_CHECK_EN is defined, include port err, registered at DONE entry as err = diff[8] XOR diff[7], i.e. the true difference lies outside -128..127, indicating a faulty adder sum.
REQ-026 SHALL, when SUB8S_RANGE_CHECK_EN is undefined, omit port err and its logic; b and the timing are identical to the defined case.

Verification
REQ-027 SHALL cover: a=0x05, s=0x00A, out_ready=1 -> out_valid 9 cycles after accept, b=0x05, err=0.
REQ-028 SHALL cover: a=0x80, s=0x17F (-129) -> b=0xFF (-1), err=0; and a=0x80, s=0x100 (-256) -> b=0x80, err=0.
REQ-029 SHALL cover: a=0x00, s=0x080 (+128) -> b=0x80, err=1 (macro defined); same stimulus with macro undefined -> b=0x80, no err port.
REQ-030 SHALL cover: out_ready held 0 for 5 cycles after out_valid -> b and out_valid stable, in_ready=0 throughout; release -> in_ready=1 in the next cycle.
REQ-031 SHALL cover: rst pulsed at SHIFT bit 4 -> no out_valid; a fresh request a=0x7F, s=0x0FE -> b=0x7F, err=0.
REQ-032 SHALL cover: random regression of 10k pairs (A,B) fed as s=A+B -> b==B, err=0.
